icache_dm_line: RTL and testbench

Parametrised direct-mapped instruction cache with multi-word lines. It sits between the CPU fetch port (inst_sram_*) and the memory arbiter (inst_cache_*). It returns hit data in the same cycle as the request. On a miss it stalls the CPU and refills the whole line with a word-sequential FSM. It adds whole-cache invalidation, which single-word caches lack.

---
 rtl/icache_dm_line.sv | 149 ++++++++++++++
 tb/tb_icache_dm_line.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_dm_line.sv
// icache_dm_line
// Direct-mapped instruction cache with multi-word lines, placed between the
// CPU fetch port and the memory arbiter. A hit returns data in the request
// cycle. A miss stalls the CPU while a word-sequential FSM refills the line.
// A one-cycle flush pulse invalidates every line.
//
// Ports:
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   inst_sram_en/addr    fetch request and byte address (tag|index|word|00)
//   inst_sram_rdata      fetch data, valid when en=1 and stall=0
//   inst_sram_stall      CPU holds en/addr while high
//   inst_flush           one-cycle pulse, invalidates all lines
//   inst_cache_req/addr  arbiter word-read request and word address
//   inst_cache_rdata     arbiter read data
//   inst_cache_dok       data-valid strobe for the requested word
module icache_dm_line #(
  parameter int unsigned INDEX_BITS = 7,
  parameter int unsigned WORD_BITS  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_rdata,
  output logic        inst_sram_stall,
  input  logic        inst_flush,
  output logic        inst_cache_req,
  output logic [31:0] inst_cache_addr,
  input  logic [31:0] inst_cache_rdata,
  input  logic        inst_cache_dok
);

  localparam int unsigned TAG_BITS = 30 - INDEX_BITS - WORD_BITS;
  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned WORDS    = 1 << WORD_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    FILLED = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [TAG_BITS-1:0]     miss_tag_q, miss_tag_d;
  logic [INDEX_BITS-1:0]   miss_idx_q, miss_idx_d;
  logic [WORD_BITS-1:0]    cnt_q, cnt_d;
  logic                    abort_q, abort_d;
  logic [LINES-1:0]        valid_q, valid_d;

  // Tag and data arrays carry no reset; valid bits gate their use.
  logic [TAG_BITS-1:0]     tag_mem  [LINES];
  logic [31:0]             data_mem [LINES*WORDS];

  logic [TAG_BITS-1:0]     addr_tag;
  logic [INDEX_BITS-1:0]   addr_idx;
  logic [WORD_BITS-1:0]    addr_word;
  logic                    aligned;
  logic                    fetch;
  logic                    hit;
  logic                    data_we;
  logic                    last_word;

  assign addr_tag  = inst_sram_addr[31 -: TAG_BITS];
  assign addr_idx  = inst_sram_addr[2+WORD_BITS +: INDEX_BITS];
  assign addr_word = inst_sram_addr[2 +: WORD_BITS];
  assign aligned   = (inst_sram_addr[1:0] == 2'b00);
  assign fetch     = inst_sram_en & aligned;
  assign hit       = fetch & valid_q[addr_idx] & (tag_mem[addr_idx] == addr_tag)
                     & (state_q == IDLE);

  assign inst_sram_rdata = hit ? data_mem[{addr_idx, addr_word}] : '0;

  assign data_we   = (state_q == REFILL) & inst_cache_dok;
  assign last_word = (cnt_q == '1);

  always_comb begin
    state_d         = state_q;
    miss_tag_d      = miss_tag_q;
    miss_idx_d      = miss_idx_q;
    cnt_d           = cnt_q;
    abort_d         = abort_q;
    valid_d         = valid_q;
    inst_sram_stall = 1'b0;
    inst_cache_req  = 1'b0;
    inst_cache_addr = {inst_sram_addr[31:2], 2'b00};

    case (state_q)
      IDLE: begin
        inst_sram_stall = fetch & ~hit;
        if (fetch && !hit) begin
          state_d    = REFILL;
          miss_tag_d = addr_tag;
          miss_idx_d = addr_idx;
          cnt_d      = '0;
          abort_d    = 1'b0;
        end
      end
      REFILL: begin
        inst_sram_stall = 1'b1;
        inst_cache_req  = 1'b1;
        inst_cache_addr = {miss_tag_q, miss_idx_q, cnt_q, 2'b00};
        // A flush mid-refill lets the arbiter transaction finish but keeps
        // the line from being marked valid.
        if (inst_flush) abort_d = 1'b1;
        if (inst_cache_dok) begin
          cnt_d = cnt_q + 1'b1;
          if (last_word) begin
            state_d = FILLED;
            if (!abort_q) valid_d[miss_idx_q] = 1'b1;
          end
        end
      end
      FILLED: begin
        inst_sram_stall = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides any valid bit set in the same cycle.
    if (inst_flush) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (data_we) begin
      data_mem[{miss_idx_q, cnt_q}] <= inst_cache_rdata;
      if (last_word) tag_mem[miss_idx_q] <= miss_tag_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      cnt_q      <= '0;
      abort_q    <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
      cnt_q      <= cnt_d;
      abort_q    <= abort_d;
      valid_q    <= valid_d;
    end
  end

endmodule

// File: tb/tb_icache_dm_line.sv
module tb_icache_dm_line;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        inst_sram_stall;
  logic        inst_flush;
  logic        inst_cache_req;
  logic [31:0] inst_cache_addr;
  logic [31:0] inst_cache_rdata;
  logic        inst_cache_dok;

  always #5 clk = ~clk;

  icache_dm_line #(.INDEX_BITS(7), .WORD_BITS(2)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .inst_sram_en     (inst_sram_en),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_rdata  (inst_sram_rdata),
    .inst_sram_stall  (inst_sram_stall),
    .inst_flush       (inst_flush),
    .inst_cache_req   (inst_cache_req),
    .inst_cache_addr  (inst_cache_addr),
    .inst_cache_rdata (inst_cache_rdata),
    .inst_cache_dok   (inst_cache_dok)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [31:0] exp_rdata_q[$];
  logic [31:0] exp_addr_q[$];
  bit          pending = 0;
  int unsigned waits = 0;
  int unsigned doks = 0;
  int unsigned dok_pct = 100;
  int unsigned flush_on_dok = 0;
  bit          spurious = 0;
  bit          flush_by_resp = 0;

  // Backing memory: explicit words where loaded, address hash elsewhere.
  logic [31:0] mem [logic [31:0]];
  // Reference cache contents: which line holds which tag.
  bit          mvalid [128];
  logic [20:0] mtag   [128];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 128; i++) mvalid[i] = 0;
  endtask

  // Arbiter responder: checks each served word address against the queue.
  always @(negedge clk) begin
    if (flush_by_resp) begin
      inst_flush    = 1'b0;
      flush_by_resp = 0;
    end
    inst_cache_dok   = 1'b0;
    inst_cache_rdata = $urandom;
    if (resetn && inst_cache_req) begin
      if ($urandom_range(99) < dok_pct) begin
        inst_cache_dok   = 1'b1;
        inst_cache_rdata = mem_rd(inst_cache_addr);
        doks++;
        if (exp_addr_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL req_addr: unexpected request %h, required none", inst_cache_addr);
        end else begin
          check("req_addr", inst_cache_addr, exp_addr_q.pop_front());
        end
        if (flush_on_dok != 0 && doks == flush_on_dok) begin
          inst_flush    = 1'b1;
          flush_by_resp = 1;
          flush_on_dok  = 0;
        end
      end else begin
        waits++;
      end
    end else if (spurious && $urandom_range(3) == 0) begin
      inst_cache_dok = 1'b1;
    end
  end

  // CPU-side monitor: a pending fetch completes when stall drops.
  always @(negedge clk) begin
    if (pending && !inst_sram_stall) begin
      if (exp_rdata_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL fetch_rdata: got %h with no expectation queued", inst_sram_rdata);
      end else begin
        check("fetch_rdata", inst_sram_rdata, exp_rdata_q.pop_front());
      end
      pending = 0;
    end
  end

  // Issue an aligned fetch; fl_dok != 0 pulses flush on that dok of a miss.
  task automatic fetch(input logic [31:0] a, input int unsigned fl_dok);
    logic [6:0]  idx;
    logic [20:0] tg;
    bit          miss;
    int unsigned nref;
    int unsigned sc;
    idx = a[10:4];
    tg  = a[31:11];
    sc  = 0;
    @(posedge clk) #1;
    miss = !(mvalid[idx] && mtag[idx] == tg);
    nref = miss ? 1 : 0;
    if (miss && fl_dok >= 1 && fl_dok <= 4) nref = 2;
    for (int r = 0; r < int'(nref); r++)
      for (int w = 0; w < 4; w++) begin
        logic [1:0] wb;
        wb = w[1:0];
        exp_addr_q.push_back({tg, idx, wb, 2'b00});
      end
    if (miss) begin
      if (fl_dok != 0) model_clear();
      mvalid[idx] = 1;
      mtag[idx]   = tg;
    end
    exp_rdata_q.push_back(mem_rd(a));
    waits          = 0;
    doks           = 0;
    flush_on_dok   = miss ? fl_dok : 0;
    inst_sram_en   = 1'b1;
    inst_sram_addr = a;
    pending        = 1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      #1;
      if (!pending) break;
      sc++;
    end
    if (pending) begin
      n_tests++;
      n_fail++;
      $display("FAIL fetch_timeout: addr %h still stalled, required completion", a);
      pending = 0;
      exp_rdata_q.delete();
      exp_addr_q.delete();
    end
    check("stall_cycles", sc, waits + 6 * nref);
  endtask

  task automatic do_flush();
    @(posedge clk) #1;
    inst_sram_en = 1'b0;
    inst_flush   = 1'b1;
    @(posedge clk) #1;
    inst_flush = 1'b0;
    model_clear();
  endtask

  task automatic misaligned(input logic [31:0] a);
    @(posedge clk) #1;
    inst_sram_en   = 1'b1;
    inst_sram_addr = a;
    @(negedge clk);
    check("mis_stall", {31'd0, inst_sram_stall}, 32'd0);
    check("mis_req", {31'd0, inst_cache_req}, 32'd0);
    check("mis_rdata", inst_sram_rdata, 32'd0);
    inst_sram_en = 1'b0;
  endtask

  // Reset asserted after the 2nd word of a refill was accepted; a must miss.
  task automatic reset_mid(input logic [31:0] a);
    bit got;
    got = 0;
    @(posedge clk) #1;
    for (int w = 0; w < 4; w++) begin
      logic [1:0] wb;
      wb = w[1:0];
      exp_addr_q.push_back({a[31:4], wb, 2'b00});
    end
    doks           = 0;
    flush_on_dok   = 0;
    inst_sram_en   = 1'b1;
    inst_sram_addr = a;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      if (doks >= 2) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL reset_wait: only %0d doks seen, required 2", doks);
    end
    #2 resetn = 1'b0;
    #1;
    check("rst_req", {31'd0, inst_cache_req}, 32'd0);
    check("rst_idle_addr", inst_cache_addr, {a[31:2], 2'b00});
    check("rst_stall", {31'd0, inst_sram_stall}, 32'd1);
    inst_sram_en = 1'b0;
    exp_addr_q.delete();
    model_clear();
    @(posedge clk) #1;
    resetn = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int unsigned r;
    resetn           = 1'b0;
    inst_sram_en     = 1'b0;
    inst_sram_addr   = '0;
    inst_flush       = 1'b0;
    inst_cache_dok   = 1'b0;
    inst_cache_rdata = '0;
    model_clear();
    for (int w = 0; w < 4; w++) mem[32'h1000 + 4 * w] = 32'hA0 + w;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req", {31'd0, inst_cache_req}, 32'd0);
    check("reset_stall", {31'd0, inst_sram_stall}, 32'd0);
    check("reset_rdata", inst_sram_rdata, 32'd0);
    resetn = 1'b1;

    fetch(32'h0000_1000, 0);
    fetch(32'h0000_1004, 0);
    fetch(32'h0000_1008, 0);
    fetch(32'h0000_100C, 0);
    fetch(32'h0000_1800, 0);
    fetch(32'h0000_1000, 0);
    fetch(32'h0000_2000, 2);
    fetch(32'h0000_2004, 0);
    fetch(32'h0000_3008, 4);
    do_flush();
    fetch(32'h0000_1000, 0);
    misaligned(32'h0000_1002);
    reset_mid(32'h0000_4000);
    fetch(32'h0000_4000, 0);
    fetch(32'h0000_400C, 0);

    dok_pct  = 60;
    spurious = 1;
    for (int i = 0; i < 150; i++) begin
      a = 32'h0001_0000 | (32'($urandom_range(3)) << 11) | (32'($urandom_range(3)) << 4)
          | (32'($urandom_range(3)) << 2);
      r = $urandom_range(9);
      if (r == 0)      do_flush();
      else if (r == 1) misaligned(a | 32'($urandom_range(1, 3)));
      else if (r == 2) fetch(a, $urandom_range(1, 4));
      else             fetch(a, 0);
    end
    spurious = 0;
    @(posedge clk) #1;
    inst_sram_en = 1'b0;
    repeat (2) @(posedge clk);
    check("addr_queue_empty", exp_addr_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
